// File: rtl/io_cfg_pkg.sv
// Shared types and size helpers for the io_block configuration loader.
package io_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    COMMIT,
    ERROR
  } state_t;

  function automatic int unsigned seg_w(input int unsigned ws, input int unsigned wd,
                                        input int unsigned wg);
    return ws + wd + wg;
  endfunction

  function automatic int unsigned cfg_w(input int unsigned seg, input int unsigned extin,
                                        input int unsigned extout);
    return (extin + extout) * seg;
  endfunction

  function automatic int unsigned num_words(input int unsigned cw, input int unsigned ww);
    return (cw + ww - 1) / ww;
  endfunction

  // First bit of pin p's track segment in the config image.
  function automatic int unsigned pin_base(input int unsigned p, input int unsigned seg);
    return p * seg;
  endfunction

endpackage

// File: rtl/io_cfg_seg_check.sv
// Per-pin track drive check: inputs must not collide with earlier inputs,
// outputs may read at most one track.
module io_cfg_seg_check #(
  parameter int unsigned SEG = 16
) (
  input  logic [SEG-1:0] seg,
  input  logic [SEG-1:0] mask,
  input  logic           is_output,
  output logic           conflict,
  output logic [SEG-1:0] new_mask
);

  always_comb begin
    conflict = 1'b0;
    new_mask = mask;
    if (is_output) begin
      // seg & (seg-1) is non-zero exactly when two or more bits are set
      conflict = |(seg & (seg - SEG'(1)));
    end else begin
      conflict = |(seg & mask);
      new_mask = mask | seg;
    end
  end

endmodule

// File: rtl/io_cfg_loader.sv
// Word-serial config loader for io_block: shadow assembly, drive check, atomic commit.
// Define IO_CFG_PARITY_EN to require a trailing XOR parity word after the data words.
module io_cfg_loader
  import io_cfg_pkg::*;
#(
  parameter  int unsigned WS     = 7,
  parameter  int unsigned WD     = 6,
  parameter  int unsigned WG     = 3,
  parameter  int unsigned EXTIN  = 5,
  parameter  int unsigned EXTOUT = 2,
  parameter  int unsigned WW     = 16,
  localparam int unsigned SEG    = seg_w(WS, WD, WG),
  localparam int unsigned CW     = cfg_w(SEG, EXTIN, EXTOUT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [WW-1:0] in_data,
  output logic          in_ready,
  output logic [CW-1:0] c,
  output logic          cfg_valid,
  output logic          busy,
  output logic          err
);

  localparam int unsigned NW  = num_words(CW, WW);
  localparam int unsigned NP  = EXTIN + EXTOUT;
  localparam int unsigned SHW = NW * WW;
`ifdef IO_CFG_PARITY_EN
  localparam int unsigned NWORDS = NW + 1;
`else
  localparam int unsigned NWORDS = NW;
`endif
  localparam int unsigned CNT_W = $clog2(NWORDS + 1);
  localparam int unsigned PIN_W = $clog2(NP + 1);

  state_t           state;
  state_t           state_next;
  logic [SHW-1:0]   shadow;
  logic [CNT_W-1:0] wcnt;
  logic [PIN_W-1:0] pin;
  logic [SEG-1:0]   mask;
  logic [SEG-1:0]   new_mask;
  logic [SEG-1:0]   seg;
  logic             is_output;
  logic             conflict;
  logic             last_word;
  logic             last_pin;
`ifdef IO_CFG_PARITY_EN
  logic [WW-1:0]    parity;
`endif

  assign last_word = (wcnt == CNT_W'(NWORDS - 1));
  assign last_pin  = (pin == PIN_W'(NP - 1));
  assign is_output = (pin >= PIN_W'(EXTIN));
  assign seg       = shadow[pin_base(int'(pin), SEG) +: SEG];

  io_cfg_seg_check #(.SEG(SEG)) u_seg_check (
    .seg       (seg),
    .mask      (mask),
    .is_output (is_output),
    .conflict  (conflict),
    .new_mask  (new_mask)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ERROR: if (start) state_next = LOAD;
      LOAD: begin
        if (in_valid && last_word) begin
`ifdef IO_CFG_PARITY_EN
          state_next = (in_data == parity) ? CHECK : ERROR;
`else
          state_next = CHECK;
`endif
        end
      end
      CHECK: begin
        if (conflict)      state_next = ERROR;
        else if (last_pin) state_next = COMMIT;
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered status outputs, steered by the current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow    <= '0;
      wcnt      <= '0;
      pin       <= '0;
      mask      <= '0;
      c         <= '0;
      cfg_valid <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
`ifdef IO_CFG_PARITY_EN
      parity    <= '0;
`endif
    end else begin
      busy     <= (state_next == LOAD) || (state_next == CHECK) || (state_next == COMMIT);
      in_ready <= (state_next == LOAD);
      case (state)
        IDLE, ERROR: begin
          if (start) begin
            shadow <= '0;
            wcnt   <= '0;
            err    <= 1'b0;
`ifdef IO_CFG_PARITY_EN
            parity <= '0;
`endif
          end
        end
        LOAD: begin
          pin  <= '0;
          mask <= '0;
          if (in_valid) begin
            wcnt <= wcnt + CNT_W'(1);
`ifdef IO_CFG_PARITY_EN
            if (wcnt < CNT_W'(NW)) begin
              shadow[int'(wcnt) * WW +: WW] <= in_data;
              parity <= parity ^ in_data;
            end
`else
            shadow[int'(wcnt) * WW +: WW] <= in_data;
`endif
          end
        end
        CHECK: begin
          mask <= new_mask;
          if (!last_pin) pin <= pin + PIN_W'(1);
        end
        COMMIT: begin
          c         <= shadow[CW-1:0];
          cfg_valid <= 1'b1;
        end
        default: ;
      endcase
      if (state_next == ERROR) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_cfg_loader.sv
// Scoreboard bench for io_cfg_loader: each load pushes its expected outcome,
// a negedge monitor compares when busy falls.
module tb_io_cfg_loader;

  localparam int unsigned CW = 112;
  localparam int unsigned WW = 16;
  localparam int unsigned NW = 7;
`ifdef IO_CFG_PARITY_EN
  localparam int unsigned NWORDS = NW + 1;
`else
  localparam int unsigned NWORDS = NW;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [WW-1:0] in_data;
  logic          in_ready;
  logic [CW-1:0] c;
  logic          cfg_valid;
  logic          busy;
  logic          err;

  io_cfg_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .c         (c),
    .cfg_valid (cfg_valid),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] c;
    logic          v;
    logic          e;
    int            words;
    int            lat;
    bit            chk_lat;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;
  logic prev_busy = 1'b0;
  int   acc_edge = 0;
  int   acc_words = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: in_ready idle check every cycle, scoreboard pop when busy falls.
  always @(negedge clk) begin
    exp_t ex;
    if (mon_en) begin
      if (!busy) begin
        n_cmp++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL in_ready_idle got %b exp 0 at cycle %0d", in_ready, cyc);
        end
      end
      if (prev_busy && !busy) begin
        if (q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          ex = q.pop_front();
          n_cmp++;
          if (c !== ex.c) begin
            n_fail++; $display("FAIL c got %h exp %h", c, ex.c);
          end
          n_cmp++;
          if (cfg_valid !== ex.v) begin
            n_fail++; $display("FAIL cfg_valid got %b exp %b", cfg_valid, ex.v);
          end
          n_cmp++;
          if (err !== ex.e) begin
            n_fail++; $display("FAIL err got %b exp %b", err, ex.e);
          end
          n_cmp++;
          if (acc_words != ex.words) begin
            n_fail++; $display("FAIL words got %0d exp %0d", acc_words, ex.words);
          end
          if (ex.chk_lat) begin
            n_cmp++;
            if (cyc - acc_edge != ex.lat) begin
              n_fail++; $display("FAIL latency got %0d exp %0d", cyc - acc_edge, ex.lat);
            end
          end
        end
        acc_words = 0;
      end
      if (in_valid && in_ready) begin
        acc_edge = cyc + 1;
        acc_words++;
      end
    end
    prev_busy = busy;
  end

  function automatic logic [CW-1:0] img7(input logic [15:0] p0, input logic [15:0] p1,
                                         input logic [15:0] p2, input logic [15:0] p3,
                                         input logic [15:0] p4, input logic [15:0] p5,
                                         input logic [15:0] p6);
    return {p6, p5, p4, p3, p2, p1, p0};
  endfunction

  task automatic push_exp(input logic [CW-1:0] ec, input logic ev, input logic ee,
                          input int lat, input bit chk);
    exp_t ex;
    ex.c = ec; ex.v = ev; ex.e = ee; ex.words = NWORDS; ex.lat = lat; ex.chk_lat = chk;
    q.push_back(ex);
  endtask

  task automatic send_image(input logic [CW-1:0] img, input bit gaps, input bit pulse_start,
                            input bit bad_par);
    logic [WW-1:0] par;
    logic [WW-1:0] w;
    logic          acc;
    int            sent;
    int            guard;
    par = '0;
    for (int k = 0; k < int'(NW); k++) begin
      w = img[k*WW +: WW];
      par = par ^ w;
    end
    if (bad_par) par = par ^ 16'h0004;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sent = 0;
    guard = 0;
    while (sent < int'(NWORDS) && guard < 200) begin
      start = (pulse_start && sent == 3) ? 1'b1 : 1'b0;
      if (gaps && $urandom_range(0, 1) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = (sent < int'(NW)) ? img[sent*WW +: WW] : par;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (sent < int'(NWORDS)) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout got %0d words exp %0d", sent, NWORDS);
    end
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy && i < 60) begin
      @(negedge clk);
      i++;
    end
    if (busy) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout got busy=%b exp 0", busy);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  logic [CW-1:0] img_a;
  logic [CW-1:0] img_b;
  logic [CW-1:0] img_m;
  logic [CW-1:0] img_c;
  logic [CW-1:0] img_g;

  initial begin
    img_a = img7(16'h0001, 16'h0002, 16'h0080, 16'h2000, 16'h0000, 16'h0001, 16'h0100);
    img_b = img7(16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000);
    img_m = img7(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 16'h0000);
    img_c = img7(16'h8000, 16'h0400, 16'h0010, 16'h0000, 16'h0008, 16'h8000, 16'h8000);
    img_g = img7(16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000);

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (c !== '0)         begin n_fail++; $display("FAIL rst_c got %h exp 0", c); end
    n_cmp++; if (cfg_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_valid got %b exp 0", cfg_valid); end
    n_cmp++; if (err !== 1'b0)     begin n_fail++; $display("FAIL rst_err got %b exp 0", err); end
    n_cmp++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Legal image commits after last word + 8 edges.
    push_exp(img_a, 1'b1, 1'b0, 8, 1'b1);
    send_image(img_a, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Two inputs on single track 0: caught at pin3.
    push_exp(img_a, 1'b1, 1'b1, 4, 1'b1);
    @(posedge clk); #1;
    send_image(img_b, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Output pin5 reading two tracks, loaded straight from ERROR.
    push_exp(img_a, 1'b1, 1'b1, 6, 1'b1);
    @(posedge clk); #1;
    send_image(img_m, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Conflict between pin0 and the last input pin on a global track.
    push_exp(img_a, 1'b1, 1'b1, 5, 1'b1);
    @(posedge clk); #1;
    send_image(img_g, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Shared output tracks are legal; random gaps and a stray start in LOAD.
    push_exp(img_c, 1'b1, 1'b0, 8, 1'b1);
    @(posedge clk); #1;
    send_image(img_c, 1'b1, 1'b1, 1'b0);
    wait_idle();

    // Reset during CHECK wipes the committed image.
    push_exp('0, 1'b0, 1'b0, 0, 1'b0);
    @(posedge clk); #1;
    send_image(img_a, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_idle();

`ifdef IO_CFG_PARITY_EN
    push_exp(img_a, 1'b1, 1'b0, 8, 1'b1);
    @(posedge clk); #1;
    send_image(img_a, 1'b0, 1'b0, 1'b0);
    wait_idle();

    push_exp(img_a, 1'b1, 1'b1, 0, 1'b1);
    @(posedge clk); #1;
    send_image(img_c, 1'b0, 1'b0, 1'b1);
    wait_idle();
`endif

    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_expect got %0d exp 0", q.size());
    end
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
